// File: rtl/face_bbox_reporter.sv
// Per-frame skin-mask bounding box and pixel count with a minimum-area detection flag,
// reported as an 11-byte packet through a byte-level UART send/done handshake.
module face_bbox_reporter #(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned CNT_W   = 19,
  parameter int unsigned MIN_PIX = 64,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic               pix_bin,
  input  logic               sof,
  input  logic               tx_done,
  output logic [7:0]         tx_byte,
  output logic               tx_send_en,
  output logic               frame_done,
  output logic               face_found,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic               overrun
);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_MIN  = CNT_W'(MIN_PIX);
  localparam logic [3:0]         IDX_LAST = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} tx_state_e;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_done_q, frame_done_d, face_found_q, face_found_d;
  logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d, y_min_q, y_min_d, y_max_q, y_max_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               tx_send_en_q, tx_send_en_d;
  tx_state_e          state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic               snap_found_q, snap_found_d;
  logic [COORD_W-1:0] snap_xmin_q, snap_xmin_d, snap_xmax_q, snap_xmax_d;
  logic [COORD_W-1:0] snap_ymin_q, snap_ymin_d, snap_ymax_q, snap_ymax_d;

  logic [COORD_W-1:0] px, py, fold_xmin, fold_xmax, fold_ymin, fold_ymax;
  logic [CNT_W-1:0]   fold_cnt;
  logic               eof_c, start_c;
  logic [3:0]         idx_next;

  function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic found,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
    logic [7:0] flags;
    logic [7:0] chk;
    flags = {7'b0, found};
    chk   = flags ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0] ^ c[15:8] ^ c[7:0] ^ d[15:8] ^ d[7:0];
    case (idx)
      4'd0:    pkt_byte = HDR;
      4'd1:    pkt_byte = flags;
      4'd2:    pkt_byte = a[15:8];
      4'd3:    pkt_byte = a[7:0];
      4'd4:    pkt_byte = b[15:8];
      4'd5:    pkt_byte = b[7:0];
      4'd6:    pkt_byte = c[15:8];
      4'd7:    pkt_byte = c[7:0];
      4'd8:    pkt_byte = d[15:8];
      4'd9:    pkt_byte = d[7:0];
      default: pkt_byte = chk;
    endcase
  endfunction

  // Raster position, accumulators and end-of-frame result latch
  always_comb begin
    px        = sof ? '0 : x_q;
    py        = sof ? '0 : y_q;
    x_d       = px;
    y_d       = py;
    fold_xmin = sof ? X_LAST : xmin_q;
    fold_xmax = sof ? '0 : xmax_q;
    fold_ymin = sof ? Y_LAST : ymin_q;
    fold_ymax = sof ? '0 : ymax_q;
    fold_cnt  = sof ? '0 : cnt_q;
    eof_c     = 1'b0;
    if (pix_valid) begin
      if (px == X_LAST) begin
        x_d = '0;
        y_d = (py == Y_LAST) ? '0 : py + COORD_W'(1);
      end else begin
        x_d = px + COORD_W'(1);
      end
      if (pix_bin) begin
        if (px < fold_xmin) fold_xmin = px;
        if (px > fold_xmax) fold_xmax = px;
        if (py < fold_ymin) fold_ymin = py;
        if (py > fold_ymax) fold_ymax = py;
        if (fold_cnt != CNT_MAX) fold_cnt = fold_cnt + CNT_W'(1);
      end
      eof_c = (px == X_LAST) && (py == Y_LAST);
    end
    xmin_d       = fold_xmin;
    xmax_d       = fold_xmax;
    ymin_d       = fold_ymin;
    ymax_d       = fold_ymax;
    cnt_d        = fold_cnt;
    frame_done_d = eof_c;
    face_found_d = face_found_q;
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;
    if (eof_c) begin
      face_found_d = (fold_cnt >= CNT_MIN);
      x_min_d      = face_found_d ? fold_xmin : '0;
      x_max_d      = face_found_d ? fold_xmax : '0;
      y_min_d      = face_found_d ? fold_ymin : '0;
      y_max_d      = face_found_d ? fold_ymax : '0;
      xmin_d       = X_LAST;
      xmax_d       = '0;
      ymin_d       = Y_LAST;
      ymax_d       = '0;
      cnt_d        = '0;
    end
  end

  // Packet transmit FSM; a frame arriving while busy is dropped and flagged
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tx_byte_d    = tx_byte_q;
    tx_send_en_d = 1'b0;
    overrun_d    = overrun_q;
    snap_found_d = snap_found_q;
    snap_xmin_d  = snap_xmin_q;
    snap_xmax_d  = snap_xmax_q;
    snap_ymin_d  = snap_ymin_q;
    snap_ymax_d  = snap_ymax_q;
    start_c      = 1'b0;
    idx_next     = idx_q + 4'd1;
    case (state_q)
      ST_IDLE: start_c = frame_done_q;
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          if (idx_q < IDX_LAST) begin
            idx_d        = idx_next;
            state_d      = ST_SEND;
            tx_send_en_d = 1'b1;
            tx_byte_d    = pkt_byte(idx_next, snap_found_q, 16'(snap_xmin_q), 16'(snap_xmax_q),
                                    16'(snap_ymin_q), 16'(snap_ymax_q));
          end else begin
            state_d = ST_IDLE;
            start_c = frame_done_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_done_q && !start_c) overrun_d = 1'b1;
    if (start_c) begin
      state_d      = ST_SEND;
      idx_d        = '0;
      tx_send_en_d = 1'b1;
      tx_byte_d    = HDR;
      snap_found_d = face_found_q;
      snap_xmin_d  = x_min_q;
      snap_xmax_d  = x_max_q;
      snap_ymin_d  = y_min_q;
      snap_ymax_d  = y_max_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      xmin_q       <= X_LAST;
      xmax_q       <= '0;
      ymin_q       <= Y_LAST;
      ymax_q       <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      face_found_q <= 1'b0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
      overrun_q    <= 1'b0;
      tx_byte_q    <= '0;
      tx_send_en_q <= 1'b0;
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      snap_found_q <= 1'b0;
      snap_xmin_q  <= '0;
      snap_xmax_q  <= '0;
      snap_ymin_q  <= '0;
      snap_ymax_q  <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      face_found_q <= face_found_d;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
      overrun_q    <= overrun_d;
      tx_byte_q    <= tx_byte_d;
      tx_send_en_q <= tx_send_en_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_found_q <= snap_found_d;
      snap_xmin_q  <= snap_xmin_d;
      snap_xmax_q  <= snap_xmax_d;
      snap_ymin_q  <= snap_ymin_d;
      snap_ymax_q  <= snap_ymax_d;
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_send_en = tx_send_en_q;
  assign frame_done = frame_done_q;
  assign face_found = face_found_q;
  assign x_min      = x_min_q;
  assign x_max      = x_max_q;
  assign y_min      = y_min_q;
  assign y_max      = y_max_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_face_bbox_reporter.sv
// Randomised self-checking bench for face_bbox_reporter on an 8x4 frame.
module tb_face_bbox_reporter;
  localparam int unsigned W    = 8;
  localparam int unsigned H    = 4;
  localparam int unsigned CW   = 3;
  localparam int unsigned NW   = 6;
  localparam int unsigned MINP = 3;

  logic          clk = 1'b0;
  logic          rst_n, pix_valid, pix_bin, sof, tx_done;
  logic [7:0]    tx_byte;
  logic          tx_send_en, frame_done, face_found, overrun;
  logic [CW-1:0] x_min, x_max, y_min, y_max;

  always #5 clk = ~clk;

  face_bbox_reporter #(.IMG_W(W), .IMG_H(H), .COORD_W(CW), .CNT_W(NW), .MIN_PIX(MINP),
                       .HDR(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_bin(pix_bin), .sof(sof),
    .tx_done(tx_done), .tx_byte(tx_byte), .tx_send_en(tx_send_en), .frame_done(frame_done),
    .face_found(face_found), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .overrun(overrun));

  int vec = 0;
  int err = 0;
  int nc  = 0;
  int ack_delay = 2;
  bit auto_ack  = 1'b1;
  int ack_cnt   = 0;
  logic [7:0] sent_b[$];
  int         sent_nc[$];
  int         done_nc[$];

  bit         exp_found;
  int         exp_xmn, exp_xmx, exp_ymn, exp_ymx;
  logic [7:0] exp_pkt[11];

  // UART stand-in: records every send request and answers with a delayed tx_done pulse
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      nc = nc + 1;
      if (tx_done) tx_done = 1'b0;
      else if (ack_cnt > 0) begin
        ack_cnt = ack_cnt - 1;
        if (ack_cnt == 0) begin
          tx_done = 1'b1;
          done_nc.push_back(nc);
        end
      end
      if (tx_send_en === 1'b1) begin
        sent_b.push_back(tx_byte);
        sent_nc.push_back(nc);
        if (auto_ack) ack_cnt = ack_delay;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: bounding box, threshold and packet straight from the frame mask
  function automatic void model_frame(input logic [31:0] m);
    int n;
    logic [15:0] c[4];
    logic [7:0] chk;
    n = 0; exp_xmn = W; exp_xmx = -1; exp_ymn = H; exp_ymx = -1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (m[y*W+x]) begin
          n++;
          if (x < exp_xmn) exp_xmn = x;
          if (x > exp_xmx) exp_xmx = x;
          if (y < exp_ymn) exp_ymn = y;
          if (y > exp_ymx) exp_ymx = y;
        end
    exp_found = (n >= MINP);
    if (!exp_found) begin exp_xmn = 0; exp_xmx = 0; exp_ymn = 0; exp_ymx = 0; end
    c[0] = 16'(exp_xmn); c[1] = 16'(exp_xmx); c[2] = 16'(exp_ymn); c[3] = 16'(exp_ymx);
    exp_pkt[0] = 8'hA5;
    exp_pkt[1] = {7'b0, exp_found};
    for (int i = 0; i < 4; i++) begin
      exp_pkt[2+2*i] = c[i][15:8];
      exp_pkt[3+2*i] = c[i][7:0];
    end
    chk = 8'h00;
    for (int k = 1; k < 10; k++) chk = chk ^ exp_pkt[k];
    exp_pkt[10] = chk;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [31:0] m, input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0; pix_bin = 1'b0; step();
      end
      pix_valid = 1'b1; pix_bin = m[i]; step();
    end
    pix_valid = 1'b0; pix_bin = 1'b0;
  endtask

  task automatic wait_sends(input int target, input int budget, input string tag);
    int t;
    t = 0;
    while (sent_b.size() < target && t < budget) begin step(); t++; end
    vec++;
    if (sent_b.size() < target) begin
      err++;
      $display("FAIL %s send_timeout: got %0d sends, required %0d", tag, sent_b.size(), target);
    end
  endtask

  function automatic logic [13:0] exp_res();
    return {1'b1, exp_found, CW'(exp_xmn), CW'(exp_xmx), CW'(exp_ymn), CW'(exp_ymx)};
  endfunction

  task automatic test_reset();
    logic [23:0] obs;
    rst_n = 1'b0; pix_valid = 1'b0; pix_bin = 1'b0; sof = 1'b0;
    repeat (3) step();
    obs = {tx_byte, tx_send_en, frame_done, face_found, x_min, x_max, y_min, y_max, overrun};
    vec++;
    if (obs !== 24'h0) begin err++; $display("FAIL reset_outputs: got %h required 000000", obs); end
    rst_n = 1'b1;
    repeat (2) step();
    obs = {tx_byte, tx_send_en, frame_done, face_found, x_min, x_max, y_min, y_max, overrun};
    vec++;
    if (obs !== 24'h0) begin err++; $display("FAIL post_reset_idle: got %h required 000000", obs); end
  endtask

  task automatic test_basic();
    logic [31:0] m;
    logic [13:0] obs;
    int base;
    m = '0; m[1*W+2] = 1'b1; m[1*W+5] = 1'b1; m[2*W+3] = 1'b1; m[3*W+4] = 1'b1;
    model_frame(m);
    base = sent_b.size();
    run_frame(m, 1'b0);
    obs = {frame_done, face_found, x_min, x_max, y_min, y_max};
    vec++;
    if (obs !== exp_res()) begin err++; $display("FAIL basic_result: got %h required %h", obs, exp_res()); end
    step();
    vec++;
    if ({frame_done, tx_send_en, tx_byte} !== {1'b0, 1'b1, 8'hA5}) begin
      err++; $display("FAIL basic_first_send: got %b/%b/%h required 0/1/a5", frame_done, tx_send_en, tx_byte);
    end
    wait_sends(base + 11, 300, "basic");
    if (sent_b.size() >= base + 11)
      for (int k = 0; k < 11; k++) begin
        vec++;
        if (sent_b[base+k] !== exp_pkt[k]) begin
          err++; $display("FAIL basic_byte%0d: got %h required %h", k, sent_b[base+k], exp_pkt[k]);
        end
      end
    repeat (40) step();
    vec++;
    if (sent_b.size() != base + 11 || overrun !== 1'b0) begin
      err++; $display("FAIL basic_send_count: got %0d sends overrun %b, required 11 and 0", sent_b.size() - base, overrun);
    end
  endtask

  task automatic test_threshold();
    logic [31:0] masks[3];
    logic [13:0] obs;
    int base;
    masks[0] = '0; masks[0][$urandom_range(0, 15)] = 1'b1; masks[0][$urandom_range(16, 31)] = 1'b1;
    masks[1] = '0; masks[1][1*W+7] = 1'b1; masks[1][2*W+7] = 1'b1; masks[1][3*W+7] = 1'b1;
    masks[2] = '0; masks[2][3*W+7] = 1'b1; masks[2][0] = 1'b1; masks[2][W-1] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      model_frame(masks[f]);
      base = sent_b.size();
      ack_delay = 1;
      run_frame(masks[f], 1'b1);
      obs = {frame_done, face_found, x_min, x_max, y_min, y_max};
      vec++;
      if (obs !== exp_res()) begin err++; $display("FAIL thresh%0d_result: got %h required %h", f, obs, exp_res()); end
      wait_sends(base + 11, 200, "thresh");
      if (sent_b.size() >= base + 11)
        for (int k = 0; k < 11; k++) begin
          vec++;
          if (sent_b[base+k] !== exp_pkt[k]) begin
            err++; $display("FAIL thresh%0d_byte%0d: got %h required %h", f, k, sent_b[base+k], exp_pkt[k]);
          end
        end
      repeat (20) step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] m;
    int base, dbase;
    m = $urandom;
    model_frame(m);
    base = sent_b.size(); dbase = done_nc.size();
    ack_delay = 100;
    run_frame(m, 1'b0);
    wait_sends(base + 1, 20, "stall_first");
    ack_delay = 2;
    wait_sends(base + 11, 2000, "stall_rest");
    repeat (20) step();
    if (sent_b.size() >= base + 11 && done_nc.size() >= dbase + 10) begin
      vec++;
      if (sent_nc[base+1] - sent_nc[base] < 101) begin
        err++; $display("FAIL stall_hold: second send after %0d cycles, required >= 101", sent_nc[base+1] - sent_nc[base]);
      end
      for (int k = 0; k < 10; k++) begin
        vec++;
        if (sent_nc[base+k+1] != done_nc[dbase+k] + 1) begin
          err++; $display("FAIL stall_latency%0d: send at %0d, required %0d", k, sent_nc[base+k+1], done_nc[dbase+k] + 1);
        end
      end
      for (int k = 0; k < 11; k++) begin
        vec++;
        if (sent_b[base+k] !== exp_pkt[k]) begin
          err++; $display("FAIL stall_byte%0d: got %h required %h", k, sent_b[base+k], exp_pkt[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] m;
    logic [13:0] obs;
    int base;
    for (int r = 0; r < 6; r++) begin
      m = (r % 2 == 0) ? ($urandom & $urandom & $urandom) : $urandom;
      model_frame(m);
      base = sent_b.size();
      ack_delay = $urandom_range(1, 4);
      run_frame(m, 1'b1);
      obs = {frame_done, face_found, x_min, x_max, y_min, y_max};
      vec++;
      if (obs !== exp_res()) begin err++; $display("FAIL rand%0d_result: got %h required %h", r, obs, exp_res()); end
      wait_sends(base + 11, 300, "rand");
      if (sent_b.size() >= base + 11)
        for (int k = 0; k < 11; k++) begin
          vec++;
          if (sent_b[base+k] !== exp_pkt[k]) begin
            err++; $display("FAIL rand%0d_byte%0d: got %h required %h", r, k, sent_b[base+k], exp_pkt[k]);
          end
        end
      repeat (20) step();
      vec++;
      if (sent_b.size() != base + 11) begin
        err++; $display("FAIL rand%0d_count: got %0d sends required 11", r, sent_b.size() - base);
      end
    end
  endtask

  task automatic test_sof();
    logic [31:0] m;
    logic [13:0] obs;
    int base, pre;
    pre = $urandom_range(3, 20);
    for (int i = 0; i < pre; i++) begin pix_valid = 1'b1; pix_bin = 1'b1; step(); end
    pix_valid = 1'b0; pix_bin = 1'b0; sof = 1'b1; step();
    sof = 1'b0;
    m = $urandom & $urandom;
    m[2*W+3] = 1'b1; m[2*W+4] = 1'b1; m[3*W+5] = 1'b1;
    model_frame(m);
    base = sent_b.size();
    ack_delay = 1;
    run_frame(m, 1'b0);
    obs = {frame_done, face_found, x_min, x_max, y_min, y_max};
    vec++;
    if (obs !== exp_res()) begin err++; $display("FAIL sof_result: got %h required %h", obs, exp_res()); end
    wait_sends(base + 11, 200, "sof");
    repeat (20) step();
  endtask

  task automatic test_overrun();
    logic [31:0] ma, mb;
    logic [7:0] exp_a[11];
    logic [13:0] obs;
    int base;
    ma = $urandom | 32'h0000_0F00;
    model_frame(ma);
    exp_a = exp_pkt;
    base = sent_b.size();
    ack_delay = 10;
    run_frame(ma, 1'b0);
    wait_sends(base + 4, 200, "ovr_a");
    mb = $urandom & $urandom;
    model_frame(mb);
    run_frame(mb, 1'b0);
    obs = {frame_done, face_found, x_min, x_max, y_min, y_max};
    vec++;
    if (obs !== exp_res()) begin err++; $display("FAIL ovr_b_result: got %h required %h", obs, exp_res()); end
    step();
    vec++;
    if (overrun !== 1'b1) begin err++; $display("FAIL ovr_flag: got %b required 1", overrun); end
    wait_sends(base + 11, 500, "ovr_a_rest");
    if (sent_b.size() >= base + 11)
      for (int k = 0; k < 11; k++) begin
        vec++;
        if (sent_b[base+k] !== exp_a[k]) begin
          err++; $display("FAIL ovr_a_byte%0d: got %h required %h", k, sent_b[base+k], exp_a[k]);
        end
      end
    repeat (80) step();
    obs = {1'b1, face_found, x_min, x_max, y_min, y_max};
    vec++;
    if (sent_b.size() != base + 11 || obs !== exp_res() || overrun !== 1'b1) begin
      err++; $display("FAIL ovr_drop: got %0d sends box %h ovr %b, required 11 sends box %h ovr 1",
                      sent_b.size() - base, obs, overrun, exp_res());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] m;
    logic [23:0] obs;
    logic [13:0] res;
    int base, n;
    m = $urandom | 32'h0018_1800;
    base = sent_b.size();
    ack_delay = 10;
    run_frame(m, 1'b0);
    wait_sends(base + 6, 300, "rmid");
    #2 rst_n = 1'b0;
    #1;
    obs = {tx_byte, tx_send_en, frame_done, face_found, x_min, x_max, y_min, y_max, overrun};
    vec++;
    if (obs !== 24'h0) begin err++; $display("FAIL rmid_async: got %h required 000000", obs); end
    step(); step();
    rst_n = 1'b1;
    n = sent_b.size();
    repeat (60) step();
    vec++;
    if (sent_b.size() != n) begin err++; $display("FAIL rmid_no_send: got %0d sends required 0", sent_b.size() - n); end
    model_frame(m);
    base = sent_b.size();
    ack_delay = 2;
    run_frame(m, 1'b1);
    res = {frame_done, face_found, x_min, x_max, y_min, y_max};
    vec++;
    if (res !== exp_res()) begin err++; $display("FAIL rmid_refill: got %h required %h", res, exp_res()); end
    wait_sends(base + 11, 300, "rmid_pkt");
    if (sent_b.size() >= base + 11)
      for (int k = 0; k < 11; k++) begin
        vec++;
        if (sent_b[base+k] !== exp_pkt[k]) begin
          err++; $display("FAIL rmid_byte%0d: got %h required %h", k, sent_b[base+k], exp_pkt[k]);
        end
      end
    repeat (20) step();
    vec++;
    if (overrun !== 1'b0) begin err++; $display("FAIL rmid_overrun: got %b required 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_stall();
    test_random();
    test_sof();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
